// File: rtl/timer_pkg.sv
// Shared types and constants for the 5-digit BCD stopwatch.
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StFull
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam int   NUM_DIGITS = 5;
  localparam bcd_t BCD_NINE   = 4'd9;

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade counter: clears, increments, wraps 9 -> 0 and emits the carry.
module bcd_decade
  import timer_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output bcd_t q_o,
  output logic carry_o
);

  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (inc_i) begin
      q_d = (q_q == BCD_NINE) ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o     = q_q;
  assign carry_o = inc_i && (q_q == BCD_NINE);

endmodule

// File: rtl/timer_core.sv
// Start/stop/clear BCD stopwatch feeding five 7-segment decoders.
// Optional lap-hold display enabled by defining TIMER_LAP_EN.
module timer_core
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100,
  parameter int unsigned WRAP    = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_stop_i,
  input  logic                    clear_i,
`ifdef TIMER_LAP_EN
  input  logic                    lap_i,
`endif
  output logic [4*NUM_DIGITS-1:0] digit_o,
  output logic [NUM_DIGITS-1:0]   blank_o,
  output logic                    running_o,
  output logic                    ovf_o
);

  localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
  localparam int unsigned PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PreMax = PW'(DIV - 1);

`ifdef TIMER_LAP_EN
  localparam int unsigned NumBtn = 3;
`else
  localparam int unsigned NumBtn = 2;
`endif

  logic [NumBtn-1:0] btn, sync1_q, sync2_q, prev_q, pulse_q;
  logic              start_pulse, clr_pulse;

`ifdef TIMER_LAP_EN
  assign btn = {lap_i, clear_i, start_stop_i};
`else
  assign btn = {clear_i, start_stop_i};
`endif

  // Two-flop synchronizer followed by a registered rising-edge pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign start_pulse = pulse_q[0];
  assign clr_pulse   = pulse_q[1];

  state_e                  state_q, state_d;
  logic [PW-1:0]           pre_q, pre_d;
  logic                    running_q, ovf_q;
  logic                    tick, all_nine, full_hit, inc_chain;
  logic [NUM_DIGITS:0]     carry;
  logic [4*NUM_DIGITS-1:0] live, disp;
  logic                    lead;

  assign tick      = (state_q == StRun) && (pre_q == PreMax);
  assign full_hit  = tick && all_nine && (WRAP == 0);
  // Saturating build must not let the chain wrap 99999 -> 00000.
  assign inc_chain = tick && !clr_pulse && !full_hit;
  assign carry[0]  = inc_chain;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : gen_digit
    bcd_decade u_decade (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (clr_pulse),
      .inc_i   (carry[k]),
      .q_o     (live[4*k +: 4]),
      .carry_o (carry[k+1])
    );
  end

  always_comb begin
    all_nine = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      all_nine = all_nine && (live[4*k +: 4] == BCD_NINE);
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    if (clr_pulse) begin
      state_d = StIdle;
      pre_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_pulse) begin
            state_d = StRun;
            pre_d   = '0;
          end
        end
        StRun: begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (full_hit) begin
            state_d = StFull;
          end else if (start_pulse) begin
            state_d = StPause;
          end
        end
        StPause: begin
          if (start_pulse) begin
            state_d = StRun;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pre_q     <= '0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      running_q <= (state_d == StRun);
      ovf_q     <= (WRAP != 0) ? carry[NUM_DIGITS] : (state_d == StFull);
    end
  end

`ifdef TIMER_LAP_EN
  logic                    lap_active_q;
  logic [4*NUM_DIGITS-1:0] shadow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lap_active_q <= 1'b0;
      shadow_q     <= '0;
    end else if (clr_pulse) begin
      lap_active_q <= 1'b0;
    end else if (pulse_q[2] && (state_q == StRun || state_q == StPause)) begin
      lap_active_q <= !lap_active_q;
      shadow_q     <= live;
    end
  end

  assign disp = lap_active_q ? shadow_q : live;
`else
  assign disp = live;
`endif

  // Leading-zero blanking; the least significant digit always shows.
  always_comb begin
    blank_o = '0;
    lead    = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lead       = lead && (disp[4*k +: 4] == 4'd0);
      blank_o[k] = lead;
    end
  end

  assign digit_o   = disp;
  assign running_o = running_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_timer_core.sv
// Directed bench for timer_core: one saturating and one wrapping instance, DIV=10.
module tb_timer_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic        lap = 1'b0;
  logic [19:0] digit, digit_w;
  logic [4:0]  blank, blank_w;
  logic        running, running_w, ovf, ovf_w;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  timer_core #(.CLK_HZ(10), .TICK_HZ(1), .WRAP(0)) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_stop_i (start),
    .clear_i      (clr),
`ifdef TIMER_LAP_EN
    .lap_i        (lap),
`endif
    .digit_o      (digit),
    .blank_o      (blank),
    .running_o    (running),
    .ovf_o        (ovf)
  );

  timer_core #(.CLK_HZ(10), .TICK_HZ(1), .WRAP(1)) u_dut_w (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_stop_i (start),
    .clear_i      (clr),
`ifdef TIMER_LAP_EN
    .lap_i        (lap),
`endif
    .digit_o      (digit_w),
    .blank_o      (blank_w),
    .running_o    (running_w),
    .ovf_o        (ovf_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise the chosen button levels for one cycle; rise lands on the next posedge.
  task automatic press(input logic s, input logic c);
    start = s;
    clr   = c;
    @(negedge clk);
    start = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic preload_00999();
    force u_dut.gen_digit[0].u_decade.q_q = 4'd9;
    force u_dut.gen_digit[1].u_decade.q_q = 4'd9;
    force u_dut.gen_digit[2].u_decade.q_q = 4'd9;
    wait_neg(1);
    release u_dut.gen_digit[0].u_decade.q_q;
    release u_dut.gen_digit[1].u_decade.q_q;
    release u_dut.gen_digit[2].u_decade.q_q;
  endtask

  task automatic preload_99998();
    force u_dut.gen_digit[0].u_decade.q_q = 4'd8;
    force u_dut.gen_digit[1].u_decade.q_q = 4'd9;
    force u_dut.gen_digit[2].u_decade.q_q = 4'd9;
    force u_dut.gen_digit[3].u_decade.q_q = 4'd9;
    force u_dut.gen_digit[4].u_decade.q_q = 4'd9;
    force u_dut_w.gen_digit[0].u_decade.q_q = 4'd8;
    force u_dut_w.gen_digit[1].u_decade.q_q = 4'd9;
    force u_dut_w.gen_digit[2].u_decade.q_q = 4'd9;
    force u_dut_w.gen_digit[3].u_decade.q_q = 4'd9;
    force u_dut_w.gen_digit[4].u_decade.q_q = 4'd9;
    wait_neg(1);
    release u_dut.gen_digit[0].u_decade.q_q;
    release u_dut.gen_digit[1].u_decade.q_q;
    release u_dut.gen_digit[2].u_decade.q_q;
    release u_dut.gen_digit[3].u_decade.q_q;
    release u_dut.gen_digit[4].u_decade.q_q;
    release u_dut_w.gen_digit[0].u_decade.q_q;
    release u_dut_w.gen_digit[1].u_decade.q_q;
    release u_dut_w.gen_digit[2].u_decade.q_q;
    release u_dut_w.gen_digit[3].u_decade.q_q;
    release u_dut_w.gen_digit[4].u_decade.q_q;
  endtask

  initial begin
    // Reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst_digit", 32'(digit), 32'h0);
    check("rst_blank", 32'(blank), 32'b11110);
    check("rst_running", 32'(running), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_ovf_w", 32'(ovf_w), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_neg(2);

    // Start latency and first ticks
    press(1'b1, 1'b0);
    wait_neg(2);
    check("start_lat_n2", 32'(running), 32'h0);
    wait_neg(1);
    check("start_lat_n3", 32'(running), 32'h1);
    wait_neg(9);
    check("tick1_early", 32'(digit), 32'h0);
    wait_neg(1);
    check("tick1", 32'(digit), 32'h1);
    check("tick1_blank", 32'(blank), 32'b11110);
    wait_neg(80);
    check("cnt9", 32'(digit), 32'h9);
    check("cnt9_blank", 32'(blank), 32'b11110);
    wait_neg(10);
    check("cnt10", 32'(digit), 32'h10);
    check("cnt10_blank", 32'(blank), 32'b11100);
    check("cnt10_running", 32'(running), 32'h1);
    wait_neg(320);
    check("cnt42", 32'(digit), 32'h42);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("arst_digit", 32'(digit), 32'h0);
    check("arst_blank", 32'(blank), 32'b11110);
    check("arst_running", 32'(running), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_neg(2);

    // Pause holds the prescaler
    press(1'b1, 1'b0);
    wait_neg(4);
    press(1'b1, 1'b0);
    wait_neg(20);
    check("pause_running", 32'(running), 32'h0);
    check("pause_digit", 32'(digit), 32'h0);
    press(1'b1, 1'b0);
    wait_neg(7);
    check("resume_early", 32'(digit), 32'h0);
    check("resume_running", 32'(running), 32'h1);
    wait_neg(1);
    check("resume_tick", 32'(digit), 32'h1);

    // Clear wins over simultaneous start
    press(1'b1, 1'b1);
    wait_neg(3);
    check("both_digit", 32'(digit), 32'h0);
    check("both_running", 32'(running), 32'h0);
    wait_neg(20);
    check("both_idle_digit", 32'(digit), 32'h0);
    check("both_idle_running", 32'(running), 32'h0);

    // Carry 00999 -> 01000
    preload_00999();
    check("pre999", 32'(digit), 32'h00999);
    check("pre999_blank", 32'(blank), 32'b11000);
    press(1'b1, 1'b0);
    wait_neg(12);
    check("c999_hold", 32'(digit), 32'h00999);
    wait_neg(1);
    check("c1000", 32'(digit), 32'h01000);
    check("c1000_blank", 32'(blank), 32'b10000);
    press(1'b0, 1'b1);
    wait_neg(3);
    check("clr_digit", 32'(digit), 32'h0);
    check("clr_running", 32'(running), 32'h0);

    // Saturate vs. wrap at 99999
    preload_99998();
    check("pre99998", 32'(digit), 32'h99998);
    check("pre99998_blank", 32'(blank), 32'b00000);
    press(1'b1, 1'b0);
    wait_neg(13);
    check("s99999", 32'(digit), 32'h99999);
    check("w99999", 32'(digit_w), 32'h99999);
    check("s99999_ovf", 32'(ovf), 32'h0);
    wait_neg(10);
    check("full_digit", 32'(digit), 32'h99999);
    check("full_ovf", 32'(ovf), 32'h1);
    check("full_running", 32'(running), 32'h0);
    check("wrap_digit", 32'(digit_w), 32'h0);
    check("wrap_blank", 32'(blank_w), 32'b11110);
    check("wrap_ovf", 32'(ovf_w), 32'h1);
    check("wrap_running", 32'(running_w), 32'h1);
    wait_neg(1);
    check("wrap_ovf_pulse", 32'(ovf_w), 32'h0);
    check("wrap_running2", 32'(running_w), 32'h1);
    check("full_ovf_level", 32'(ovf), 32'h1);
    press(1'b1, 1'b0);
    wait_neg(15);
    check("full_ign_digit", 32'(digit), 32'h99999);
    check("full_ign_ovf", 32'(ovf), 32'h1);
    check("full_ign_running", 32'(running), 32'h0);
    check("wrap_paused", 32'(running_w), 32'h0);
    press(1'b0, 1'b1);
    wait_neg(3);
    check("full_clr_digit", 32'(digit), 32'h0);
    check("full_clr_ovf", 32'(ovf), 32'h0);
    check("full_clr_running", 32'(running), 32'h0);
    check("full_clr_blank", 32'(blank), 32'b11110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_core.md
Name: timer_core

Overview:
- Upstream counting stage of the 5-digit timer. Produces five BCD digits plus per-digit blanking that feed the five hex-to-7-segment decoders.
- Implements a start/stop/clear stopwatch counting ticks of TICK_HZ derived from the system clock.
- Output digits are always valid BCD (0-9), never A-F.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz. DIV = CLK_HZ/TICK_HZ must be an integer >= 2.
- WRAP, 0. 0 = saturate at 99999; 1 = roll over to 00000.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_stop_i  in  1  debounced button level, active-high; its rising edge toggles run/pause.
- clear_i  in  1  debounced button level, active-high; its rising edge clears.
- digit_o  out  20  BCD digits; digit k at [4k+3:4k]; digit 0 is least significant.
- blank_o  out  5  1 = blank digit k (leading zero).
- running_o  out  1  high while in RUN.
- ovf_o  out  1  overflow indication (see Behaviour).

Behaviour:
- Reset and clocking: one clock, clk_i. rst_ni is asynchronous, active-low.
  - Reset state: IDLE, count 00000, prescaler 0, all synchronizers 0.
  - Reset output values: digit_o=0, blank_o=5'b11110, running_o=0, ovf_o=0.
- Input synchronization:
  - Each button passes a 2-flop synchronizer, then a registered rising-edge detect that yields a 1-cycle pulse.
  - Latency: input rise at edge N -> state change visible at edge N+3.
- States:
  - IDLE: start pulse -> RUN, prescaler=0.
  - RUN: prescaler counts 0..DIV-1. At DIV-1, a tick fires, the prescaler returns to 0 and the count increments. Start pulse -> PAUSE.
  - PAUSE: prescaler and count hold. Start pulse -> RUN; the prescaler resumes from its held value.
  - FULL (WRAP=0 only): count held at 99999, ovf_o=1 level. Start pulses are ignored; only clear exits.
- Clear: a clear pulse in any state -> IDLE, count 0, prescaler 0, ovf_o=0. Clear wins over a simultaneous start pulse. A tick coincident with clear is discarded.
- Increment and overflow:
  - BCD ripple: digit k increments when the tick is present and all lower digits are 9. A digit at 9 wraps to 0 and carries.
  - Tick at 99999 with WRAP=0 -> FULL.
  - Tick at 99999 with WRAP=1 -> 00000, state stays RUN, ovf_o is a 1-cycle pulse coincident with the wrap.
- Blanking: combinational from the count registers, so no extra latency.
  - blank_o[k] (k>=1) = 1 iff digit k and all more-significant digits are 0.
  - blank_o[0] = 0 always.
- running_o is registered: running_o = (state==RUN).

Optional Feature:
- Macro TIMER_LAP_EN.
- Defined:
  - Adds port lap_i (in, 1), synchronized and edge-detected identically to the buttons.
  - A lap pulse in RUN or PAUSE captures the current count into a shadow register, and digit_o/blank_o show the shadow while the internal count continues.
  - A second lap pulse releases the display to the live count.
  - Clear also releases it. Lap pulses in IDLE/FULL are ignored.
- Undefined: lap_i is absent and digit_o/blank_o always show the live count.

Decomposition:
- Package timer_pkg:
  - state enum {IDLE, RUN, PAUSE, FULL}
  - bcd_t (4-bit) typedef
  - constants NUM_DIGITS=5 and BCD_NINE=4'd9.
- Sub-module bcd_decade:
  - Inputs: clk_i, rst_ni, clr_i, inc_i.
  - Outputs: q_o[3:0], carry_o = inc_i && q==9.
  - Instantiated NUM_DIGITS times in a carry chain.
- Prescaler, synchronizers, edge detect and FSM live in timer_core.

Test Plan (CLK_HZ=10, TICK_HZ=1, so DIV=10):
- Reset asserted mid-RUN with count 00042 -> immediately digit_o=0, blank_o=11110, running_o=0, regardless of clock.
- Start pulse, wait 10 ticks -> digit_o=BCD 00010, blank_o=11100, running_o=1. First tick arrives 3+10 cycles after the input rise.
- Start, 5 cycles, stop, 20 idle cycles, start -> first increment occurs 5 cycles after resume (prescaler held).
- Preload to 99998, run 2 ticks:
  - WRAP=0 -> digit_o=99999, ovf_o=1, start is ignored, clear returns to IDLE.
  - WRAP=1 -> 00000, ovf_o high exactly 1 cycle, running_o stays 1.
- start_stop_i and clear_i rise on the same cycle while in RUN -> IDLE, count 0.
- Check 00009->00010 and 00999->01000 carries; blank_o goes 11110->11100 and 11000->10000 respectively.
